l2_request_arbiter: RTL and testbench
=====================================

// Module: l2_request_arbiter
//
// PURPOSE
//  N-core arbiter between per-core L2 request ports and the single l2_cache request port.
//  Replaces the fixed two-core toggle in the top level. Only cores with a valid request
//  compete; grants are round-robin or fixed-priority. The winning packet's core field is
//  stamped with the winner's index. A one-entry output register decouples core timing from L2.
//
// PARAMETERS
//  NUM_CORES      4   number of requesting cores, 1..2**CORE_ID_WIDTH
//  CORE_ID_WIDTH  4   width of l2req_packet_t.core
//  ARB_MODE       0   0 = round-robin, 1 = fixed priority (lowest index wins)
//
// PORTS
//  clk                       in   1                    clock; all state on rising edge
//  reset                     in   1                    asynchronous, active-high
//  core_l2req_packet         in   l2req_packet_t[N]    per-core request; .valid qualifies it
//  core_l2req_ready          out  [N]                  per-core accept strobe, at most one high
//  l2req_packet              out  l2req_packet_t       registered request to l2_cache
//  l2req_ready               in   1                    l2_cache consumes l2req_packet this cycle
//  pc_event_l2_arb_conflict  out  1                    pulse: capture made with >1 core valid
//
// BEHAVIOUR
//  - Reset (async, any cycle, mid-transfer included):
//    - Output register cleared: l2req_packet all-zero, so .valid=0.
//    - RR pointer = 0; pc_event = 0; core_l2req_ready = 0 while reset is high.
//    - A held packet is dropped; cores re-present after reset.
//  - Core rule: holds its packet stable with .valid=1 until core_l2req_ready[i]=1 in that
//    cycle. Acceptance happens at the rising edge ending that cycle.
//  - Output register (out_valid = l2req_packet.valid):
//    - load_en = !out_valid || l2req_ready.
//    - Winner is computed combinationally from the valid vector.
//    - When load_en and a winner exist: core_l2req_ready[winner]=1 that cycle; at the edge,
//      register <= winner packet with .core = winner index (zero-extended).
//    - l2req_ready with no winner: register .valid <= 0, payload don't-care.
//    - No load_en: register holds, all core readies 0.
//    - l2req_ready while !out_valid is ignored.
//  - Latency: core packet captured -> visible to L2 next cycle (1 cycle). Throughput 1 req/clk
//    while L2 keeps l2req_ready high (simultaneous drain+load is legal).
//  - Round-robin (ARB_MODE=0):
//    - Search starts at pointer p, then p+1 .. N-1, wraps to 0 .. p-1; first valid core wins.
//    - Each capture sets p <= (winner+1) mod NUM_CORES. Wrap N-1 -> 0.
//    - p does not change when nothing is captured, so a stalled L2 never skips a core.
//  - Fixed priority (ARB_MODE=1): lowest-index valid core wins; pointer unused (held 0).
//  - Starvation bound (RR mode): a continuously valid core is granted within NUM_CORES captures.
//  - pc_event_l2_arb_conflict: registered. High the cycle after a capture that saw >=2 valid
//    cores, 0 otherwise.
//  - NUM_CORES=1: no arbitration; core 0 always wins; .core = 0; pointer logic constant-folds.
//  - Width: pointer and winner index are $clog2(NUM_CORES) bits, min 1. Zero-extended to
//    CORE_ID_WIDTH.
//
// STRUCTURE
//  - Shared package/defines:
//    - l2req_packet_t (existing, unchanged).
//    - ARB_MODE_ROUND_ROBIN = 0, ARB_MODE_FIXED = 1.
//  - Sub-module rr_arbiter #(NUM_REQUESTERS, ARB_MODE), instantiated once:
//    - Inputs: request vector, update_en.
//    - Outputs: one-hot grant + grant index.
//    - Owns the RR pointer; advances only on update_en.
//  - Top-level RTL owns the output register, core-id stamping, ready decode and perf event.
//    It replaces the generate/toggle arbiter in the GPGPU top.
//
// TESTING
//  1. Reset with cores 0,2 valid, L2 ready=1 -> l2req_packet.valid=0, all readies 0, no event.
//  2. N=4, RR, cores 0-3 valid continuously, L2 ready=1 -> captured order 0,1,2,3,0,...;
//     event high each cycle after the first capture.
//  3. Only core 2 valid, L2 ready held 0 for 5 cycles -> captured once; ready[2] one cycle only;
//     packet .core=2 held stable 5 cycles. Ready=1 -> next cycle .valid=0.
//  4. Cores 1,3 valid, pointer=2, L2 stalls 3 cycles after first capture -> core 3 first, then
//     core 1 (pointer frozen during stall); no core accepted during stall.
//  5. ARB_MODE=1, cores 1,2 always valid -> core 1 wins every capture; core 2 never granted
//     while core 1 valid.
//  6. Reset asserted while register holds core 3's packet and L2 stalled -> output clears
//     immediately (async). After release, first grant searches from core 0.

Source files
------------

// File: rtl/l2_request_arbiter_pkg.sv
// ============================================================================
// Module : l2_request_arbiter_pkg
// Brief  : Shared L2 request packet type and arbitration mode constants.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package l2_request_arbiter_pkg;

  localparam int L2_CORE_ID_WIDTH     = 4;
  localparam int ARB_MODE_ROUND_ROBIN = 0;
  localparam int ARB_MODE_FIXED       = 1;

  typedef struct packed {
    logic                        valid;
    logic [L2_CORE_ID_WIDTH-1:0] core;
    logic                        write;
    logic [31:0]                 addr;
    logic [31:0]                 data;
  } l2req_packet_t;

  // Index width never collapses to zero, even for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/l2_request_arbiter_rr.sv
// ============================================================================
// Module : rr_arbiter
// Brief  : Round-robin / fixed-priority grant with a pointer advanced on update.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter
  import l2_request_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS = 4,
  parameter int ARB_MODE       = ARB_MODE_ROUND_ROBIN,
  localparam int IDX_W         = idx_width(NUM_REQUESTERS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQUESTERS-1:0] i_req,
  input  logic                      i_update_en,
  output logic [NUM_REQUESTERS-1:0] o_grant,
  output logic [IDX_W-1:0]          o_grant_idx,
  output logic                      o_grant_valid
);

  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_idx;
  logic             w_found;

  // Search from the pointer with wrap; fixed mode keeps the pointer at 0.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQUESTERS; k++) begin
      if (!w_found && i_req[(int'(r_ptr) + k) % NUM_REQUESTERS]) begin
        w_found = 1'b1;
        w_idx   = IDX_W'((int'(r_ptr) + k) % NUM_REQUESTERS);
      end
    end
  end

  always_comb begin
    o_grant = '0;
    if (w_found) o_grant[w_idx] = 1'b1;
  end

  assign o_grant_idx   = w_idx;
  assign o_grant_valid = w_found;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if ((ARB_MODE == ARB_MODE_ROUND_ROBIN) && i_update_en && w_found) begin
      r_ptr <= (w_idx == IDX_W'(NUM_REQUESTERS - 1)) ? '0 : w_idx + IDX_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/l2_request_arbiter.sv
// ============================================================================
// Module : l2_request_arbiter
// Brief  : N-core arbiter feeding a one-entry registered request to the L2 cache.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module l2_request_arbiter
  import l2_request_arbiter_pkg::*;
#(
  parameter int NUM_CORES     = 4,
  parameter int CORE_ID_WIDTH = L2_CORE_ID_WIDTH,
  parameter int ARB_MODE      = ARB_MODE_ROUND_ROBIN
) (
  input  logic                 clk,
  input  logic                 reset,
  input  l2req_packet_t        core_l2req_packet [NUM_CORES],
  output logic [NUM_CORES-1:0] core_l2req_ready,
  output l2req_packet_t        l2req_packet,
  input  logic                 l2req_ready,
  output logic                 pc_event_l2_arb_conflict
);

  localparam int IDX_W = idx_width(NUM_CORES);

  logic [NUM_CORES-1:0] w_req;
  logic [NUM_CORES-1:0] w_grant;
  logic [IDX_W-1:0]     w_idx;
  logic                 w_found;
  logic                 w_load_en;
  logic                 w_capture;
  logic                 w_multi;
  l2req_packet_t        r_out;
  logic                 r_evt;

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_req
    assign w_req[g] = core_l2req_packet[g].valid;
  end

  rr_arbiter #(
    .NUM_REQUESTERS (NUM_CORES),
    .ARB_MODE       (ARB_MODE)
  ) u_arb (
    .clk           (clk),
    .rst           (reset),
    .i_req         (w_req),
    .i_update_en   (w_capture),
    .o_grant       (w_grant),
    .o_grant_idx   (w_idx),
    .o_grant_valid (w_found)
  );

  assign w_load_en = !r_out.valid || l2req_ready;
  assign w_capture = w_load_en && w_found;
  assign w_multi   = ($countones(w_req) > 1);

  // Readies are suppressed during reset so no core believes it was accepted.
  assign core_l2req_ready = (w_capture && !reset) ? w_grant : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out <= '0;
      r_evt <= 1'b0;
    end else begin
      r_evt <= w_capture && w_multi;
      if (w_capture) begin
        r_out      <= core_l2req_packet[w_idx];
        r_out.core <= CORE_ID_WIDTH'(w_idx);
      end else if (l2req_ready) begin
        r_out.valid <= 1'b0;
      end
    end
  end

  assign l2req_packet             = r_out;
  assign pc_event_l2_arb_conflict = r_evt;

endmodule

`default_nettype wire

// File: tb/tb_l2_request_arbiter.sv
// ============================================================================
// Module : tb_l2_request_arbiter
// Brief  : Random-stimulus bench for round-robin and fixed-priority instances.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_l2_request_arbiter;
  import l2_request_arbiter_pkg::*;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          reset;
  l2req_packet_t pkt_a [N];
  l2req_packet_t pkt_b [N];
  logic [N-1:0]  rdy_a, rdy_b;
  l2req_packet_t out_a, out_b;
  logic          l2r_a, l2r_b, ev_a, ev_b;

  int tests = 0;
  int fails = 0;

  // Core-side state and reference model state, index 0 = RR, 1 = fixed.
  l2req_packet_t cp   [2][N];
  logic          acc  [2][N];
  logic          l2r  [2];
  l2req_packet_t m_out[2];
  int            m_ptr[2];
  logic          m_ev [2];
  int            p_valid;
  int            p_rdy;

  always #5 clk = ~clk;

  l2_request_arbiter #(.NUM_CORES(N), .CORE_ID_WIDTH(4), .ARB_MODE(ARB_MODE_ROUND_ROBIN)) dut_rr (
    .clk(clk), .reset(reset), .core_l2req_packet(pkt_a), .core_l2req_ready(rdy_a),
    .l2req_packet(out_a), .l2req_ready(l2r_a), .pc_event_l2_arb_conflict(ev_a));

  l2_request_arbiter #(.NUM_CORES(N), .CORE_ID_WIDTH(4), .ARB_MODE(ARB_MODE_FIXED)) dut_fp (
    .clk(clk), .reset(reset), .core_l2req_packet(pkt_b), .core_l2req_ready(rdy_b),
    .l2req_packet(out_b), .l2req_ready(l2r_b), .pc_event_l2_arb_conflict(ev_b));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input int mode, input int ptr, input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      int c;
      c = (mode == 1) ? k : (ptr + k) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      pkt_a[i] = cp[0][i];
      pkt_b[i] = cp[1][i];
    end
    l2r_a = l2r[0];
    l2r_b = l2r[1];
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_out[d] = '0;
      m_ptr[d] = 0;
      m_ev[d]  = 1'b0;
    end
  endtask

  task automatic check_out(input int d);
    l2req_packet_t o;
    o = (d == 0) ? out_a : out_b;
    if (m_out[d].valid) chk(d == 0 ? "rr_pkt" : "fp_pkt", 128'(o), 128'(m_out[d]));
    else                chk(d == 0 ? "rr_vld" : "fp_vld", 128'(o.valid), 128'(1'b0));
    chk(d == 0 ? "rr_evt" : "fp_evt", 128'(d == 0 ? ev_a : ev_b), 128'(m_ev[d]));
  endtask

  // One cycle, entered at a falling edge: drive, check, advance model, wait.
  task automatic cycle();
    for (int d = 0; d < 2; d++) begin
      l2r[d] = ($urandom_range(99) < p_rdy);
      for (int i = 0; i < N; i++) begin
        if (!cp[d][i].valid || acc[d][i]) begin
          cp[d][i].valid = (d == 1 && (i == 1 || i == 2)) ? 1'b1 : ($urandom_range(99) < p_valid);
          cp[d][i].core  = 4'($urandom);
          cp[d][i].write = 1'($urandom);
          cp[d][i].addr  = $urandom;
          cp[d][i].data  = $urandom;
        end
        acc[d][i] = 1'b0;
      end
    end
    drive();
    #1;
    for (int d = 0; d < 2; d++) begin
      logic [N-1:0] v;
      int           w;
      logic [N-1:0] er;
      for (int i = 0; i < N; i++) v[i] = cp[d][i].valid;
      w  = (!m_out[d].valid || l2r[d]) ? pick(d, m_ptr[d], v) : -1;
      er = (w >= 0) ? N'(1) << w : '0;
      chk(d == 0 ? "rr_ready" : "fp_ready", 128'(d == 0 ? rdy_a : rdy_b), 128'(er));
      check_out(d);
      if (w >= 0) begin
        m_out[d]      = cp[d][w];
        m_out[d].core = 4'(w);
        m_ptr[d]      = (d == 1) ? 0 : (w + 1) % N;
        m_ev[d]       = ($countones(v) >= 2);
        acc[d][w]     = 1'b1;
      end else begin
        if (l2r[d]) m_out[d].valid = 1'b0;
        m_ev[d] = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic run(input int n, input int pv, input int pr);
    p_valid = pv;
    p_rdy   = pr;
    for (int c = 0; c < n; c++) cycle();
  endtask

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      l2r[d] = 1'b1;
      for (int i = 0; i < N; i++) begin
        cp[d][i]       = '0;
        cp[d][i].valid = (i == 0 || i == 2);
        cp[d][i].addr  = 32'h100 + i;
        acc[d][i]      = 1'b0;
      end
    end
    drive();
    model_reset();
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_pkt_rr", 128'(out_a), 128'(0));
    chk("rst_pkt_fp", 128'(out_b), 128'(0));
    chk("rst_rdy_rr", 128'(rdy_a), 128'(0));
    chk("rst_rdy_fp", 128'(rdy_b), 128'(0));
    chk("rst_evt_rr", 128'(ev_a), 128'(0));
    reset = 1'b0;

    run(200, 100, 100);  // all busy, L2 always ready
    run(300, 50, 60);
    run(200, 30, 20);    // heavy stall
    run(300, 70, 90);

    // Asynchronous reset while L2 stalls and the register is full.
    run(10, 90, 0);
    #2 reset = 1'b1;
    #1;
    chk("arst_pkt_rr", 128'(out_a), 128'(0));
    chk("arst_pkt_fp", 128'(out_b), 128'(0));
    chk("arst_rdy_rr", 128'(rdy_a), 128'(0));
    chk("arst_evt_rr", 128'(ev_a), 128'(0));
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    run(300, 60, 70);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
